ula_accumulator: RTL and testbench

Sequential front-end that drives the combinational add/subtract ULA and consumes its result. It accepts operations over a valid/ready handshake and presents an accumulator and a captured operand to the ULA's `input_a`/`input_b`/`sel`. It writes `output_s` back into the accumulator and adds sticky overflow detection and a completed-operation counter, which the ULA itself does not provide.

---
 rtl/ula_accumulator.sv | 132 +++++++++++++
 tb/tb_ula_accumulator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_accumulator.sv
// Sequential front-end for the combinational add/subtract ULA: valid/ready intake,
// accumulator write-back, sticky overflow and op counter. Option: ULA_ACC_SATURATE_EN.
module ula_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic             ula_sel,
  input  logic [WIDTH-1:0] ula_s,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             out_valid,
  output logic [7:0]       op_count
);

  // state | meaning
  // IDLE  | ready for a request; operands captured on the accepting edge
  // EXEC  | ULA driven from captured regs; acc/ovf written at end of cycle
  // DONE  | out_valid pulse; op counter advances on exit
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // ULA inputs are frozen here so they hold steady outside EXEC
          op_d    = in_op;
          a_d     = acc_q;
          b_d     = in_data;
          sel_d   = (in_op == OP_SUB);
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = DONE;
        case (op_q)
          OP_LOAD: acc_d = b_q;
          OP_ADD: begin
            acc_d = ula_s;
            if (ula_s < acc_q) begin
              ovf_d = 1'b1;
`ifdef ULA_ACC_SATURATE_EN
              acc_d = '1;
`endif
            end
          end
          OP_SUB: begin
            acc_d = ula_s;
            if (b_q > acc_q) begin
              ovf_d = 1'b1;
`ifdef ULA_ACC_SATURATE_EN
              acc_d = '0;
`endif
            end
          end
          OP_CLEAR: begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
          default: acc_d = acc_q;
        endcase
      end
      DONE: begin
        out_valid = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ula_a    = a_q;
  assign ula_b    = b_q;
  assign ula_sel  = sel_q;
  assign acc      = acc_q;
  assign ovf      = ovf_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_ula_accumulator.sv
// Scoreboard bench for ula_accumulator: random and directed ops against an arithmetic
// reference model; a monitor pops expected acc/ovf on every out_valid pulse.
module tb_ula_accumulator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_data;
  logic [W-1:0] ula_a, ula_b, ula_s;
  logic         ula_sel;
  logic [W-1:0] acc;
  logic         ovf;
  logic         out_valid;
  logic [7:0]   op_count;

  ula_accumulator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .ula_a(ula_a), .ula_b(ula_b),
    .ula_sel(ula_sel), .ula_s(ula_s), .acc(acc), .ovf(ovf),
    .out_valid(out_valid), .op_count(op_count)
  );

  // combinational ULA
  assign ula_s = ula_sel ? (ula_a - ula_b) : (ula_a + ula_b);

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int ovf;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int acc_m = 0, ovf_m = 0, cnt_m = 0, phase = 0;
  int exp_a = 0, exp_b = 0, exp_sel = 0;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_apply(int op, int d);
    int sum;
    case (op)
      0: acc_m = d;
      1: begin
        sum = acc_m + d;
        if (sum > 15) begin
          ovf_m = 1;
`ifdef ULA_ACC_SATURATE_EN
          acc_m = 15;
`else
          acc_m = sum - 16;
`endif
        end else acc_m = sum;
      end
      2: begin
        if (d > acc_m) begin
          ovf_m = 1;
`ifdef ULA_ACC_SATURATE_EN
          acc_m = 0;
`else
          acc_m = acc_m - d + 16;
`endif
        end else acc_m = acc_m - d;
      end
      default: begin
        acc_m = 0;
        ovf_m = 0;
      end
    endcase
  endfunction

  // one clock cycle, entered and left at a falling edge
  task automatic cycle(input bit v, input logic [1:0] op, input logic [3:0] d, output bit accepted);
    exp_t e;
    chk("in_ready", int'(in_ready), (phase == 0) ? 1 : 0);
    chk("out_valid", int'(out_valid), (phase == 2) ? 1 : 0);
    chk("op_count", int'(op_count), cnt_m);
    chk("ula_a", int'(ula_a), exp_a);
    chk("ula_b", int'(ula_b), exp_b);
    chk("ula_sel", int'(ula_sel), exp_sel);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    accepted = (phase == 0) && v;
    if (accepted) begin
      exp_a   = acc_m;
      exp_b   = int'(d);
      exp_sel = (op == 2'b10) ? 1 : 0;
      model_apply(int'(op), int'(d));
      e.acc = acc_m;
      e.ovf = ovf_m;
      sbq.push_back(e);
    end
    @(negedge clk);
    if (accepted) phase = 1;
    else if (phase == 1) phase = 2;
    else if (phase == 2) begin
      phase = 0;
      cnt_m = (cnt_m + 1) % 256;
    end
  endtask

  task automatic idle_cycles(input int n);
    bit g;
    for (int i = 0; i < n; i++)
      cycle(1'b0, 2'($urandom_range(3)), 4'($urandom_range(15)), g);
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] d);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) cycle(1'b1, op, d, got);
    chk("issue_accept", int'(got), 1);
    idle_cycles(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_acc", int'(acc), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_op_count", int'(op_count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ula", int'({ula_a, ula_b, ula_sel}), 0);
    repeat (2) @(negedge clk);
    chk("rst_held_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    acc_m = 0; ovf_m = 0; cnt_m = 0; phase = 0;
    exp_a = 0; exp_b = 0; exp_sel = 0;
    sbq.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sbq.size() == 0) chk("sb_unexpected_out_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("sb_acc", int'(acc), e.acc);
        chk("sb_ovf", int'(ovf), e.ovf);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit g;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = '0;
    @(negedge clk);
    do_reset();

    // reset while in EXEC aborts the LOAD
    cycle(1'b1, 2'b00, 4'd5, g);
    chk("rstexec_accept", int'(g), 1);
    do_reset();
    idle_cycles(3);
    chk("rstexec_acc", int'(acc), 0);
    chk("rstexec_count", int'(op_count), 0);

    issue(2'b00, 4'd3);
    issue(2'b01, 4'd1);
    chk("add_acc", int'(acc), 4);
    chk("add_ovf", int'(ovf), 0);
    chk("add_count", int'(op_count), 2);

    issue(2'b00, 4'd15);
    issue(2'b01, 4'd2);
    chk("addovf_ovf", int'(ovf), 1);
`ifdef ULA_ACC_SATURATE_EN
    chk("addovf_acc", int'(acc), 15);
`else
    chk("addovf_acc", int'(acc), 1);
`endif

    issue(2'b11, 4'd0);
    issue(2'b00, 4'd7);
    issue(2'b10, 4'd8);
    chk("subovf_ovf", int'(ovf), 1);
`ifdef ULA_ACC_SATURATE_EN
    chk("subovf_acc", int'(acc), 0);
`else
    chk("subovf_acc", int'(acc), 15);
`endif
    issue(2'b01, 4'd0);
    chk("sticky_ovf", int'(ovf), 1);
    issue(2'b11, 4'd9);
    chk("clear_acc", int'(acc), 0);
    chk("clear_ovf", int'(ovf), 0);

    // back-to-back: valid held, data changing every cycle
    for (int i = 0; i < 30; i++)
      cycle(1'b1, 2'($urandom_range(3)), 4'($urandom_range(15)), g);
    idle_cycles(3);

    // random traffic with gaps
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(9) < 7), 2'($urandom_range(3)), 4'($urandom_range(15)), g);
    idle_cycles(3);

    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      issue(2'b00, 4'($urandom_range(15)));
      if (i == 254) chk("wrap_255", int'(op_count), 255);
      if (i == 255) chk("wrap_0", int'(op_count), 0);
    end

    idle_cycles(3);
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
